// File: rtl/sa_feeder.sv
// Control and diagonal-skew stage feeding an output-stationary systolic array:
// sequences operand reads, skews A/B streams, pulses per-PE clc and walks the drain.
module sa_feeder #(
    parameter int unsigned data_width = 8,
    parameter int unsigned num_row    = 16,
    parameter int unsigned num_col    = 16,
    parameter int unsigned k_max      = 256,
    parameter int unsigned k_w        = $clog2(k_max + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [k_w-1:0]                         k_len,
    output logic                                   rd_en,
    output logic [k_w-1:0]                         rd_addr,
    input  logic [num_row:1][data_width-1:0]       a_col,
    input  logic [num_col:1][data_width-1:0]       b_row,
    output logic                                   en,
    output logic [num_row:1][num_col:1]            clc,
    output logic [num_row:1][data_width-1:0]       row_in,
    output logic [num_col:1][data_width-1:0]       col_in,
    output logic [num_row-1:0]                     row_out_valid,
    output logic                                   out_valid,
    output logic [$clog2(num_row+1)-1:0]           out_row,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned row_w = $clog2(num_row + 1);
    localparam int unsigned cnt_w = $clog2(k_max + 2*num_row + num_col + 2);

    localparam logic [2:0] st_idle  = 3'd0;
    localparam logic [2:0] st_feed  = 3'd1;
    localparam logic [2:0] st_flush = 3'd2;
    localparam logic [2:0] st_drain = 3'd3;
    localparam logic [2:0] st_done  = 3'd4;

    localparam logic [num_row-1:0] top_row = {1'b1, {(num_row-1){1'b0}}};

    logic [2:0]       state, state_nxt;
    logic [cnt_w-1:0] cnt, cnt_nxt;      // tile cycle number of the current cycle
    logic [k_w-1:0]   kl, kl_nxt;
    logic [cnt_w-1:0] flush_end, drain_end, drain_idx;
    logic             feed_nxt, flush_nxt, drain_nxt;
    logic             vld;               // a_col/b_row carry a requested slice this cycle

    // Next-state and cycle counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        kl_nxt    = kl;
        flush_end = cnt_w'(kl) + cnt_w'(num_row + num_col);
        drain_end = flush_end + cnt_w'(num_row);
        case (state)
            st_idle: begin
                if (start && (k_len != '0)) begin
                    state_nxt = st_feed;
                    cnt_nxt   = cnt_w'(1);
                    kl_nxt    = k_len;
                end
            end
            st_feed: begin
                cnt_nxt = cnt + cnt_w'(1);
                if (cnt == cnt_w'(kl)) state_nxt = st_flush;
            end
            st_flush: begin
                cnt_nxt = cnt + cnt_w'(1);
                if (cnt == flush_end) state_nxt = st_drain;
            end
            st_drain: begin
                cnt_nxt = cnt + cnt_w'(1);
                if (cnt == drain_end) state_nxt = st_done;
            end
            st_done: begin
                state_nxt = st_idle;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = st_idle;
                cnt_nxt   = '0;
            end
        endcase
        feed_nxt  = (state_nxt == st_feed);
        flush_nxt = (state_nxt == st_flush);
        drain_nxt = (state_nxt == st_drain);
        drain_idx = cnt_nxt - flush_end - cnt_w'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= st_idle;
            cnt           <= '0;
            kl            <= '0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            en            <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            out_valid     <= 1'b0;
            row_out_valid <= '0;
            out_row       <= '0;
            vld           <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            kl            <= kl_nxt;
            rd_en         <= feed_nxt;
            rd_addr       <= feed_nxt ? k_w'(cnt_nxt - cnt_w'(1)) : '0;
            en            <= feed_nxt || flush_nxt;
            busy          <= feed_nxt || flush_nxt || drain_nxt;
            done          <= (state_nxt == st_done);
            out_valid     <= drain_nxt;
            row_out_valid <= drain_nxt ? (top_row >> drain_idx) : '0;
            out_row       <= drain_nxt ? (row_w'(num_row) - row_w'(drain_idx)) : '0;
            vld           <= rd_en;
        end
    end

    // PE(r,c) completes one cycle after its last operand: cycle k_len+2+i+j
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clc <= '0;
        end else begin
            for (int r = 1; r <= int'(num_row); r++) begin
                for (int c = 1; c <= int'(num_col); c++) begin
                    clc[r][c] <= (feed_nxt || flush_nxt) &&
                                 (cnt_nxt == cnt_w'(kl_nxt) + cnt_w'(2 + num_row - r + num_col - c));
                end
            end
        end
    end

    // A skew: row r delayed by num_row-r cycles, zero outside the valid window
    for (genvar r = 1; r <= num_row; r++) begin : g_row
        localparam int unsigned dly = num_row - r;
        logic [data_width-1:0] s0;
        assign s0 = vld ? a_col[r] : '0;
        if (dly == 0) begin : g_pass
            assign row_in[r] = s0;
        end else begin : g_dly
            logic [data_width-1:0] pipe [dly];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < dly; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= s0;
                    for (int unsigned k = 1; k < dly; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign row_in[r] = pipe[dly-1];
        end
    end

    // B skew: column c delayed by num_col-c cycles
    for (genvar c = 1; c <= num_col; c++) begin : g_col
        localparam int unsigned dly = num_col - c;
        logic [data_width-1:0] s0;
        assign s0 = vld ? b_row[c] : '0;
        if (dly == 0) begin : g_pass
            assign col_in[c] = s0;
        end else begin : g_dly
            logic [data_width-1:0] pipe [dly];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < dly; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= s0;
                    for (int unsigned k = 1; k < dly; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign col_in[c] = pipe[dly-1];
        end
    end

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder (4x4): per-cycle timing checks, a behavioural
// output-stationary array fed by the DUT, and golden matrix products.
module tb_sa_feeder;

    localparam int NR = 4;
    localparam int NC = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [8:0]            k_len;
    logic                  rd_en;
    logic [8:0]            rd_addr;
    logic [NR:1][7:0]      a_col;
    logic [NC:1][7:0]      b_row;
    logic                  en;
    logic [NR:1][NC:1]     clc;
    logic [NR:1][7:0]      row_in;
    logic [NC:1][7:0]      col_in;
    logic [NR-1:0]         row_out_valid;
    logic                  out_valid;
    logic [2:0]            out_row;
    logic                  busy;
    logic                  done;

    sa_feeder #(.data_width(8), .num_row(NR), .num_col(NC), .k_max(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_col(a_col), .b_row(b_row),
        .en(en), .clc(clc), .row_in(row_in), .col_in(col_in),
        .row_out_valid(row_out_valid), .out_valid(out_valid), .out_row(out_row),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int mode;
        int fc;     // first clc cycle
        int lc;     // last clc cycle
        int df;     // first drain cycle
        int dc;     // done cycle
        bit poke;   // re-assert start during FEED and DRAIN
    } vec_t;

    vec_t tbl [6];
    int n_cmp = 0;
    int n_bad = 0;

    int A [1:NR][0:7];
    int B [0:7][1:NC];
    int G [1:NR][1:NC];
    int acc [1:NR][1:NC];
    int res [1:NR][1:NC];
    int ar [1:NR][1:NC];
    int br [1:NR][1:NC];
    logic pe;
    logic [8:0] pa;

    task automatic chk(input string name, input int t, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, got, exp);
        end
    endtask

    // Operand buffer: slice valid the cycle after rd_en, garbage otherwise
    task automatic drive_ops(input logic ren, input logic [8:0] addr);
        for (int r = 1; r <= NR; r++) a_col[r] = ren ? 8'(A[r][addr]) : 8'($urandom);
        for (int c = 1; c <= NC; c++) b_row[c] = ren ? 8'(B[addr][c]) : 8'($urandom);
    endtask

    // Output-stationary array: A moves toward col 1, B toward row 1
    task automatic sa_step();
        int na [1:NR][1:NC];
        int nb [1:NR][1:NC];
        int a;
        int b;
        for (int r = 1; r <= NR; r++) begin
            for (int c = 1; c <= NC; c++) begin
                a = (c == NC) ? int'(row_in[r]) : ar[r][c+1];
                b = (r == NR) ? int'(col_in[c]) : br[r+1][c];
                na[r][c] = a;
                nb[r][c] = b;
                if (clc[r][c]) begin
                    res[r][c] = acc[r][c] + a * b;
                    acc[r][c] = 0;
                end else begin
                    acc[r][c] = acc[r][c] + a * b;
                end
            end
        end
        ar = na;
        br = nb;
    endtask

    task automatic run_tile(input vec_t v);
        int fc_o = -1;
        int lc_o = -1;
        int df_o = -1;
        int dc_o = -1;
        int ds;
        int idx;
        int s;
        logic [NR:1][7:0]  er;
        logic [NC:1][7:0]  ec;
        logic [NR:1][NC:1] eclc;
        logic [63:0] got_row;
        logic [63:0] exp_row;
        for (int r = 1; r <= NR; r++)
            for (int k = 0; k < 8; k++)
                A[r][k] = (v.mode == 0) ? 1 : (v.mode == 1) ? r + k : int'($urandom_range(0, 15));
        for (int k = 0; k < 8; k++)
            for (int c = 1; c <= NC; c++)
                B[k][c] = (v.mode == 0) ? 2 : (v.mode == 1) ? c : int'($urandom_range(0, 15));
        for (int r = 1; r <= NR; r++)
            for (int c = 1; c <= NC; c++) begin
                G[r][c] = 0;
                for (int k = 0; k < v.k; k++) G[r][c] += A[r][k] * B[k][c];
                acc[r][c] = 0; res[r][c] = -1; ar[r][c] = 0; br[r][c] = 0;
            end
        ds = v.k + NR + NC + 1;

        @(negedge clk);
        start = 1'b1;
        k_len = 9'(v.k);
        drive_ops(1'b0, 9'd0);
        #1;
        chk("idle_before_start", 0, 128'({busy, en, rd_en, done}), 128'(0));
        pe = rd_en;
        pa = rd_addr;

        for (int t = 1; t <= v.dc; t++) begin
            @(negedge clk);
            start = v.poke && (t == 2 || t == ds + 1);
            k_len = v.poke ? 9'd5 : 9'(v.k);
            drive_ops(pe, pa);
            #1;
            chk("rd", t, 128'({rd_en, rd_addr}),
                (t >= 1 && t <= v.k) ? 128'({1'b1, 9'(t - 1)}) : 128'(0));
            chk("en", t, 128'(en), 128'(t >= 1 && t <= v.k + NR + NC));
            chk("busy", t, 128'(busy), 128'(t >= 1 && t <= v.k + 2*NR + NC));
            chk("done", t, 128'(done), 128'(t == v.k + 2*NR + NC + 1));
            idx = t - ds;
            if (idx >= 0 && idx < NR)
                chk("drain", t, 128'({row_out_valid, out_valid, out_row}),
                    128'({4'b1000 >> idx, 1'b1, 3'(NR - idx)}));
            else
                chk("drain", t, 128'({row_out_valid, out_valid, out_row}), 128'(0));
            for (int r = 1; r <= NR; r++)
                for (int c = 1; c <= NC; c++)
                    eclc[r][c] = (t == 2 + v.k + (NR - r) + (NC - c));
            chk("clc", t, 128'(clc), 128'(eclc));
            for (int r = 1; r <= NR; r++) begin
                s = t - (NR - r);
                er[r] = (s >= 2 && s <= v.k + 1) ? 8'(A[r][s-2]) : 8'd0;
            end
            for (int c = 1; c <= NC; c++) begin
                s = t - (NC - c);
                ec[c] = (s >= 2 && s <= v.k + 1) ? 8'(B[s-2][c]) : 8'd0;
            end
            chk("row_in", t, 128'(row_in), 128'(er));
            chk("col_in", t, 128'(col_in), 128'(ec));

            if (clc != '0) begin
                if (fc_o < 0) fc_o = t;
                lc_o = t;
            end
            if (out_valid && df_o < 0) df_o = t;
            if (done) dc_o = t;
            if (en) sa_step();
            if (out_valid && out_row >= 3'd1 && out_row <= 3'(NR)) begin
                for (int c = 1; c <= NC; c++) begin
                    got_row[16*(c-1) +: 16] = 16'(res[int'(out_row)][c]);
                    exp_row[16*(c-1) +: 16] = 16'(G[int'(out_row)][c]);
                end
                chk("sa_result_row", t, 128'(got_row), 128'(exp_row));
            end
            pe = rd_en;
            pa = rd_addr;
        end
        chk("first_clc_cycle", v.dc, 128'(fc_o), 128'(v.fc));
        chk("last_clc_cycle", v.dc, 128'(lc_o), 128'(v.lc));
        chk("first_drain_cycle", v.dc, 128'(df_o), 128'(v.df));
        chk("done_cycle", v.dc, 128'(dc_o), 128'(v.dc));
    endtask

    function automatic logic [127:0] all_out();
        return {rd_en, rd_addr, en, clc, row_in, col_in, row_out_valid, out_valid, out_row, busy, done};
    endfunction

    initial begin
        vec_t ab;
        int seen_done;
        tbl[0] = '{3, 0, 5, 11, 12, 16, 1'b0};
        tbl[1] = '{3, 1, 5, 11, 12, 16, 1'b1};
        tbl[2] = '{1, 2, 3,  9, 10, 14, 1'b0};
        tbl[3] = '{1, 1, 3,  9, 10, 14, 1'b0};
        tbl[4] = '{5, 2, 7, 13, 14, 18, 1'b0};
        tbl[5] = '{2, 0, 4, 10, 11, 15, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        k_len = '0;
        a_col = '0;
        b_row = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_ops(1'b0, 9'd0);
        #1;
        chk("reset_outputs", 0, all_out(), 128'(0));

        // k_len == 0 must be ignored
        @(negedge clk);
        start = 1'b1;
        k_len = 9'd0;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("zero_k_idle", t, 128'({busy, rd_en, en, done}), 128'(0));
        end

        // Consecutive entries start in the cycle after the previous done
        for (int n = 0; n < 6; n++) run_tile(tbl[n]);

        // Synchronous reset at cycle 6 aborts the tile
        @(negedge clk);
        start = 1'b1;
        k_len = 9'd3;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start = 1'b0;
            drive_ops(1'b1, 9'(t % 3));
            if (t == 6) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_ops(1'b0, 9'd0);
        #1;
        chk("abort_outputs", 7, all_out(), 128'(0));
        seen_done = 0;
        for (int t = 8; t < 28; t++) begin
            @(negedge clk);
            #1;
            if (done || busy || en) seen_done++;
        end
        chk("abort_no_resume", 28, 128'(seen_done), 128'(0));

        ab = '{2, 1, 4, 10, 11, 15, 1'b0};
        run_tile(ab);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
